button_debouncer: RTL and testbench

//   Input-conditioning stage that sits directly upstream of the ALU operand/opcode registers.
//   - Synchronises the raw board push-buttons and slide switches into the i_clock domain.
//   - Debounces each button independently.
//   - On each debounced press, emits a single-cycle pulse that drives the ALU load strobes
//     (boton1 = operand A, boton2 = operand B, boton3 = opcode), with the synchronised switch bus.

---
 rtl/button_debouncer_if.sv | 40 ++++
 rtl/button_debouncer.sv | 163 ++++++++++++++++
 tb/tb_button_debouncer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer_if
// Description : Signal bundle between the raw board inputs and the ALU-side
//               consumer of the debouncer.
//               i_boton_raw   - raw asynchronous push-buttons (1 = pressed)
//               i_swiches_raw - raw asynchronous slide switches
//               o_swiches     - synchronised switch value
//               o_boton_pulse - one-cycle strobe per accepted press
//               o_boton_level - debounced button level
//               master: board / stimulus side; slave: the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_debouncer_if #(
    parameter int BUS_SIZE  = 8,
    parameter int N_BUTTONS = 3
);
    logic [N_BUTTONS-1:0] i_boton_raw;
    logic [BUS_SIZE-1:0]  i_swiches_raw;
    logic [BUS_SIZE-1:0]  o_swiches;
    logic [N_BUTTONS-1:0] o_boton_pulse;
    logic [N_BUTTONS-1:0] o_boton_level;

    modport master (
        output i_boton_raw,
        output i_swiches_raw,
        input  o_swiches,
        input  o_boton_pulse,
        input  o_boton_level
    );

    modport slave (
        input  i_boton_raw,
        input  i_swiches_raw,
        output o_swiches,
        output o_boton_pulse,
        output o_boton_level
    );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Input conditioning ahead of the ALU operand/opcode registers.
//               Two-stage synchronises every button and switch bit, debounces
//               each button independently and emits a single-cycle strobe on
//               every accepted (debounced) press.
// Ports       : i_clock - system clock, rising edge
//               i_reset - asynchronous active-high reset
//               bus     - button_debouncer_if.slave (raw inputs in,
//                         synchronised switches / pulses / levels out)
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int BUS_SIZE        = 8,
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic           i_clock,
    input  wire logic           i_reset,
    button_debouncer_if.slave   bus
);

    localparam int C_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW = 2'd0,
        DEB_RISE = 2'd1,
        HIGH     = 2'd2,
        DEB_FALL = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic [N_BUTTONS-1:0] btn_meta_q;
    logic [N_BUTTONS-1:0] btn_sync_q;
    logic [BUS_SIZE-1:0]  sw_meta_q;
    logic [BUS_SIZE-1:0]  sw_sync_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= bus.i_boton_raw;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.i_swiches_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    assign bus.o_swiches = sw_sync_q;

    // ------------------------------------------------------------------
    // Per-button debounce FSMs
    // ------------------------------------------------------------------
    logic [N_BUTTONS-1:0] w_pulse;
    logic [N_BUTTONS-1:0] w_level;

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_button
        state_t             state_q;
        state_t             state_d;
        logic [C_CNT_W-1:0] cnt_q;
        logic [C_CNT_W-1:0] cnt_d;
        logic               pulse_q;
        logic               pulse_d;
        logic               level_q;
        logic               w_s;

        assign w_s = btn_sync_q[gi];

        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                state_q <= IDLE_LOW;
                cnt_q   <= C_CNT_ZERO;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
                // Level is registered from the next state so it changes on
                // the same edge the FSM enters/leaves the high side.
                level_q <= (state_d == HIGH) || (state_d == DEB_FALL);
            end
        end

        // cnt holds how many consecutive samples have agreed with the new
        // level so far; it is compared against DEBOUNCE_CYCLES-1 because the
        // first agreeing sample is the one that leaves the idle state.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = HIGH;
                            cnt_d   = C_CNT_ZERO;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = DEB_RISE;
                            cnt_d   = C_CNT_ONE;
                        end
                    end
                end
                DEB_RISE: begin
                    if (!w_s) begin
                        state_d = IDLE_LOW;
                        cnt_d   = C_CNT_ZERO;
                    end else if (cnt_q == C_CNT_LAST) begin
                        state_d = HIGH;
                        cnt_d   = C_CNT_ZERO;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = IDLE_LOW;
                            cnt_d   = C_CNT_ZERO;
                        end else begin
                            state_d = DEB_FALL;
                            cnt_d   = C_CNT_ONE;
                        end
                    end
                end
                DEB_FALL: begin
                    if (w_s) begin
                        state_d = HIGH;
                        cnt_d   = C_CNT_ZERO;
                    end else if (cnt_q == C_CNT_LAST) begin
                        state_d = IDLE_LOW;
                        cnt_d   = C_CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = C_CNT_ZERO;
                end
            endcase
        end

        assign w_pulse[gi] = pulse_q;
        assign w_level[gi] = level_q;
    end

    assign bus.o_boton_pulse = w_pulse;
    assign bus.o_boton_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4).
//               A run-length reference model predicts switches, pulses and
//               levels every cycle; directed scenarios also check the timing
//               figures directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int BUS_SIZE  = 8;
    localparam int N_BUTTONS = 3;
    localparam int DEB       = 4;

    logic i_clock;
    logic i_reset;
    int   total;
    int   bad;

    button_debouncer_if #(.BUS_SIZE(BUS_SIZE), .N_BUTTONS(N_BUTTONS)) bus ();

    button_debouncer #(
        .BUS_SIZE        (BUS_SIZE),
        .N_BUTTONS       (N_BUTTONS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // ------------------------------------------------------------------
    // Reference model: the accepted level flips once the synchronised
    // input has disagreed with it for DEB consecutive samples; a flip to 1
    // produces a strobe in the following cycle.
    // ------------------------------------------------------------------
    logic [N_BUTTONS-1:0] m_s1, m_s2, m_lvl, m_pulse;
    logic [BUS_SIZE-1:0]  m_sw1, m_sw2;
    int                   m_run [N_BUTTONS];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
        m_sw1 = '0; m_sw2 = '0;
        for (int b = 0; b < N_BUTTONS; b++) m_run[b] = 0;
    endtask

    task automatic model_edge(input logic [N_BUTTONS-1:0] raw, input logic [BUS_SIZE-1:0] sw);
        for (int b = 0; b < N_BUTTONS; b++) begin
            m_pulse[b] = 1'b0;
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == DEB) begin
                    m_lvl[b]   = m_s2[b];
                    m_run[b]   = 0;
                    m_pulse[b] = m_s2[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2  = m_s1;
        m_s1  = raw;
        m_sw2 = m_sw1;
        m_sw1 = sw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one edge, then compare all outputs with the model.
    task automatic step(input logic [N_BUTTONS-1:0] b, input logic [BUS_SIZE-1:0] sw);
        bus.i_boton_raw   = b;
        bus.i_swiches_raw = sw;
        @(posedge i_clock);
        if (!i_reset) model_edge(b, sw);
        #1;
        chk("pulse", 32'(bus.o_boton_pulse), 32'(m_pulse));
        chk("level", 32'(bus.o_boton_level), 32'(m_lvl));
        chk("swiches", 32'(bus.o_swiches), 32'(m_sw2));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pulse"}, 32'(bus.o_boton_pulse), 32'd0);
        chk({tag, "_level"}, 32'(bus.o_boton_level), 32'd0);
        chk({tag, "_sw"},    32'(bus.o_swiches),     32'd0);
    endtask

    // Asynchronous reset between clock edges, held for two edges.
    task automatic async_reset(input string tag);
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        check_all_zero(tag);
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        check_all_zero({tag, "_held"});
        i_reset = 1'b0;
    endtask

    initial begin
        int first_p;
        int npulse;
        int nglitch;
        logic [N_BUTTONS-1:0] held;

        total = 0;
        bad   = 0;
        model_reset();
        i_reset           = 1'b1;
        bus.i_boton_raw   = '0;
        bus.i_swiches_raw = '0;
        repeat (3) @(posedge i_clock);
        #1;
        check_all_zero("por");
        i_reset = 1'b0;

        // 1: reset mid-run with buttons high, then released while still held
        repeat (10) step(3'b111, 8'hA5);
        chk("s1_level_before", 32'(bus.o_boton_level), 32'h7);
        async_reset("s1_reset");
        first_p = -1; npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b111, 8'h00);
            if (bus.o_boton_pulse == 3'b111) begin
                npulse++;
                if (first_p < 0) first_p = i;
            end
        end
        chk("s1_pulse_at", 32'(first_p), 32'(DEB + 1));
        chk("s1_pulse_cnt", 32'(npulse), 32'd1);
        repeat (12) step(3'b000, 8'h00);

        // 2: button 0 held high from edge 0
        first_p = -1; npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b001, 8'h00);
            if (bus.o_boton_pulse[0]) begin
                npulse++;
                if (first_p < 0) first_p = i;
            end
            if (i == DEB) chk("s2_level_pre", 32'(bus.o_boton_level[0]), 32'd0);
            if (i == DEB + 1) chk("s2_level_on", 32'(bus.o_boton_level[0]), 32'd1);
        end
        chk("s2_pulse_at", 32'(first_p), 32'(DEB + 1));
        chk("s2_pulse_cnt", 32'(npulse), 32'd1);
        repeat (12) step(3'b000, 8'h00);

        // 3: button 1 bounces 1,0,1,1,0 then stays high; final rise at index 5
        first_p = -1; npulse = 0;
        for (int i = 0; i < 16; i++) begin
            logic [4:0] pat;
            pat = 5'b01101;
            step((i < 5) ? {1'b0, pat[i], 1'b0} : 3'b010, 8'h00);
            if (bus.o_boton_pulse[1]) begin
                npulse++;
                if (first_p < 0) first_p = i;
            end
        end
        chk("s3_pulse_at", 32'(first_p), 32'(5 + DEB + 1));
        chk("s3_pulse_cnt", 32'(npulse), 32'd1);
        repeat (12) step(3'b000, 8'h00);

        // 4: switches FF then 02, each visible two edges later
        step(3'b000, 8'hFF);
        chk("s4_sw_delay", 32'(bus.o_swiches), 32'h00);
        step(3'b000, 8'hFF);
        chk("s4_sw_ff", 32'(bus.o_swiches), 32'hFF);
        step(3'b000, 8'h02);
        chk("s4_sw_hold", 32'(bus.o_swiches), 32'hFF);
        step(3'b000, 8'h02);
        chk("s4_sw_02", 32'(bus.o_swiches), 32'h02);

        // 5: buttons 0 and 2 rise together
        first_p = -1; npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b101, 8'h02);
            if (bus.o_boton_pulse != 3'b000) begin
                npulse++;
                if (first_p < 0) first_p = i;
                chk("s5_pulse_val", 32'(bus.o_boton_pulse), 32'h5);
            end
        end
        chk("s5_pulse_at", 32'(first_p), 32'(DEB + 1));
        chk("s5_pulse_cnt", 32'(npulse), 32'd1);
        repeat (12) step(3'b000, 8'h02);

        // 6: press, 2-cycle low glitches, real release, re-press
        npulse = 0; nglitch = 0;
        for (int i = 0; i < 10; i++) begin
            step(3'b001, 8'h3C);
            if (bus.o_boton_pulse[0]) npulse++;
        end
        for (int r = 0; r < 3; r++) begin
            step(3'b000, 8'h3C); if (bus.o_boton_pulse[0]) nglitch++;
            step(3'b000, 8'h3C); if (bus.o_boton_pulse[0]) nglitch++;
            repeat (4) begin
                step(3'b001, 8'h3C); if (bus.o_boton_pulse[0]) nglitch++;
            end
        end
        chk("s6_glitch_pulses", 32'(nglitch), 32'd0);
        chk("s6_glitch_level", 32'(bus.o_boton_level[0]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 8'h3C);
            if (bus.o_boton_pulse[0]) npulse++;
        end
        chk("s6_released", 32'(bus.o_boton_level[0]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(3'b001, 8'h3C);
            if (bus.o_boton_pulse[0]) npulse++;
        end
        chk("s6_pulse_cnt", 32'(npulse), 32'd2);

        // Random: buttons toggle with probability 1/4 per cycle per bit,
        // random switches, one reset in the middle.
        held = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N_BUTTONS; b++)
                if ($urandom_range(3) == 0) held[b] = ~held[b];
            step(held, 8'($urandom));
            if (i == 200) async_reset("rnd_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
